// File: rtl/bayer_linebuf_nrow.sv
// Rolling LINES-row line buffer for the Bayer demosaic path: one vertically aligned
// column per pixel, border fill for rows above the frame top, overflow guard and phase flags.
`timescale 1ns/1ps
module bayer_linebuf_nrow #(
  parameter int ADDR_BITS    = 11,
  parameter int DATA_WIDTH   = 12,
  parameter int LINES        = 5,
  parameter int BORDER_MODE  = 0,
  parameter int X_PHASE_INIT = 0,
  parameter int Y_PHASE_INIT = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vs_in,
  input  logic                          hs_in,
  input  logic                          de_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic                          vs_out,
  output logic                          hs_out,
  output logic                          de_out,
  output logic [LINES*DATA_WIDTH-1:0]   taps_out,
  output logic [$clog2(LINES):0]        rows_valid,
  output logic                          x_phase,
  output logic                          y_phase,
  output logic                          overflow
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam int NSLOT = LINES - 1;
  localparam int SW    = $clog2(LINES);
  localparam int RVW   = SW + 1;
  localparam logic [ADDR_BITS-1:0] X_MAX     = {ADDR_BITS{1'b1}};
  localparam logic [SW-1:0]        SLOT_LAST = SW'(NSLOT - 1);
  localparam logic [SW-1:0]        LD_MAX    = SW'(NSLOT);
  localparam logic                 XP_INIT   = 1'(X_PHASE_INIT);
  localparam logic                 YP_INIT   = 1'(Y_PHASE_INIT);

  logic [DATA_WIDTH-1:0]            d1_r, d2_r;
  logic [ADDR_BITS-1:0]             x1_r;
  logic                             de1_r, de2_r, ovf1_r, ovf2_r;
  logic                             vs1_r, vs2_r, hs1_r, hs2_r, vs_prev_r;
  logic [SW-1:0]                    wr_slot_r, lines_done_r, ws2_r, ld2_r;
  logic [DATA_WIDTH-1:0]            mem_r [NSLOT][DEPTH];
  logic [NSLOT-1:0][DATA_WIDTH-1:0] rd_r;
  logic [2*NSLOT*DATA_WIDTH-1:0]    dbl_s;
  logic [NSLOT*DATA_WIDTH-1:0]      ordered_s;
  logic [DATA_WIDTH-1:0]            fill_s;
  logic [LINES*DATA_WIDTH-1:0]      taps_s;

  // Stage 1: capture pixel, sync and column address; x saturates once the line overruns the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs1_r  <= 1'b1;
      hs1_r  <= 1'b1;
      de1_r  <= 1'b0;
      d1_r   <= '0;
      x1_r   <= '0;
      ovf1_r <= 1'b0;
    end else begin
      vs1_r <= vs_in;
      hs1_r <= hs_in;
      de1_r <= de_in;
      d1_r  <= vs_in ? '0 : data_in;
      if (vs_in || !de_in || !de1_r) begin
        x1_r   <= '0;
        ovf1_r <= 1'b0;
      end else if (x1_r == X_MAX) begin
        x1_r   <= X_MAX;
        ovf1_r <= 1'b1;
      end else begin
        x1_r   <= x1_r + ADDR_BITS'(1);
        ovf1_r <= 1'b0;
      end
    end
  end

  // Slot rotation, valid-line count and the sticky overflow flag; frame start wins over line end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_slot_r    <= '0;
      lines_done_r <= '0;
      vs_prev_r    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      vs_prev_r <= vs_in;
      if (vs_in) begin
        wr_slot_r    <= '0;
        lines_done_r <= '0;
      end else if (de1_r && !de_in) begin
        wr_slot_r <= (wr_slot_r == SLOT_LAST) ? '0 : wr_slot_r + SW'(1);
        if (lines_done_r != LD_MAX) lines_done_r <= lines_done_r + SW'(1);
      end
      if (vs_in && !vs_prev_r) overflow <= 1'b0;
      else if (ovf1_r)         overflow <= 1'b1;
    end
  end

  // Read-first line RAMs: every slot is read at x, only the oldest slot takes the new pixel.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NSLOT; s++) begin
      rd_r[s] <= mem_r[s][x1_r];
      if (de1_r && !ovf1_r && (wr_slot_r == SW'(s))) mem_r[s][x1_r] <= d1_r;
    end
  end

  // Stage 2: align the current pixel and slot/line context with the RAM read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs2_r  <= 1'b1;
      hs2_r  <= 1'b1;
      de2_r  <= 1'b0;
      d2_r   <= '0;
      ovf2_r <= 1'b0;
      ws2_r  <= '0;
      ld2_r  <= '0;
    end else begin
      vs2_r  <= vs1_r;
      hs2_r  <= hs1_r;
      de2_r  <= de1_r;
      d2_r   <= d1_r;
      ovf2_r <= ovf1_r;
      ws2_r  <= wr_slot_r;
      ld2_r  <= lines_done_r;
    end
  end

  // Rotate slots so index 0 is the oldest line, then apply border fill to rows not yet valid.
  always_comb begin
    taps_s    = '0;
    dbl_s     = {rd_r, rd_r};
    ordered_s = (NSLOT*DATA_WIDTH)'(dbl_s >> (int'(ws2_r) * DATA_WIDTH));
    fill_s    = DATA_WIDTH'(ordered_s >> ((NSLOT - int'(ld2_r)) * DATA_WIDTH));
    for (int k = 0; k < LINES; k++) begin
      if (k == LINES - 1) begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = d2_r;
      end else if ((LINES - 1 - k) <= int'(ld2_r)) begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = ordered_s[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (BORDER_MODE == 0) begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (ld2_r == '0) begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = d2_r;
      end else begin
        taps_s[k*DATA_WIDTH +: DATA_WIDTH] = fill_s;
      end
    end
  end

  // Stage 3: registered outputs; taps freeze on overrun pixels and between lines.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_out     <= 1'b1;
      hs_out     <= 1'b1;
      de_out     <= 1'b0;
      taps_out   <= '0;
      rows_valid <= '0;
      x_phase    <= 1'b0;
      y_phase    <= 1'b0;
    end else begin
      vs_out <= vs2_r;
      hs_out <= hs2_r;
      de_out <= de2_r;
      if (de2_r && !ovf2_r) taps_out <= taps_s;
      if (de2_r) begin
        rows_valid <= RVW'(ld2_r) + RVW'(1);
        x_phase    <= de_out ? ~x_phase : XP_INIT;
      end
      if (vs2_r)                 y_phase <= YP_INIT;
      else if (de_out && !de2_r) y_phase <= ~y_phase;
    end
  end

endmodule

// File: tb/tb_bayer_linebuf_nrow.sv
// Bench: three buffer configurations driven in parallel, checked every cycle against a
// frame-history model (zero fill, replicate fill, and a 3-bit address variant for overrun).
`timescale 1ns/1ps
module tb_bayer_linebuf_nrow;
  localparam int DW  = 12;
  localparam int L   = 5;
  localparam int NT  = 3;
  localparam int RVW = $clog2(L) + 1;

  logic clk = 1'b0;
  logic reset, vs_in, hs_in, de_in;
  logic [DW-1:0] data_in;
  logic vs_o [NT], hs_o [NT], de_o [NT], xp_o [NT], yp_o [NT], ov_o [NT];
  logic [L*DW-1:0] tp_o [NT];
  logic [RVW-1:0]  rv_o [NT];

  always #5 clk = ~clk;

  bayer_linebuf_nrow #(.ADDR_BITS(11), .DATA_WIDTH(DW), .LINES(L), .BORDER_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .vs_out(vs_o[0]), .hs_out(hs_o[0]), .de_out(de_o[0]), .taps_out(tp_o[0]),
    .rows_valid(rv_o[0]), .x_phase(xp_o[0]), .y_phase(yp_o[0]), .overflow(ov_o[0]));
  bayer_linebuf_nrow #(.ADDR_BITS(11), .DATA_WIDTH(DW), .LINES(L), .BORDER_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .vs_out(vs_o[1]), .hs_out(hs_o[1]), .de_out(de_o[1]), .taps_out(tp_o[1]),
    .rows_valid(rv_o[1]), .x_phase(xp_o[1]), .y_phase(yp_o[1]), .overflow(ov_o[1]));
  bayer_linebuf_nrow #(.ADDR_BITS(3), .DATA_WIDTH(DW), .LINES(L), .BORDER_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .vs_in(vs_in), .hs_in(hs_in), .de_in(de_in), .data_in(data_in),
    .vs_out(vs_o[2]), .hs_out(hs_o[2]), .de_out(de_o[2]), .taps_out(tp_o[2]),
    .rows_valid(rv_o[2]), .x_phase(xp_o[2]), .y_phase(yp_o[2]), .overflow(ov_o[2]));

  typedef struct {
    logic vs, hs, de;
    logic [NT-1:0][L*DW-1:0] taps;
    int rv, scen, line, x;
  } ent_t;

  ent_t pipe [$];
  logic [DW-1:0] hist [0:15][0:15];
  int   n, in_x, pos, tests, fails;
  logic prev_de_in, prev_de_out, y_exp;

  // Expected window: row of age a comes from line n-a; rows above the frame top are filled.
  function automatic logic [L*DW-1:0] model_taps(int border, int amax, int ln, int x);
    logic [L*DW-1:0] t;
    int xe, ld, a;
    t  = '0;
    xe = (x > amax) ? amax : x;
    ld = (ln > L-1) ? L-1 : ln;
    for (int k = 0; k < L; k++) begin
      a = L - 1 - k;
      if (a <= ld)          t[k*DW +: DW] = hist[ln-a][xe];
      else if (border == 0) t[k*DW +: DW] = '0;
      else                  t[k*DW +: DW] = hist[ln-ld][xe];
    end
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    ent_t r;
    r.vs = 1'b1; r.hs = 1'b1; r.de = 1'b0; r.taps = '0;
    r.rv = 0; r.scen = 0; r.line = 0; r.x = 0;
    pipe.delete();
    pipe.push_back(r);
    pipe.push_back(r);
    n = 0; in_x = 0; pos = 0;
    prev_de_in = 1'b0; prev_de_out = 1'b0; y_exp = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NT; i++) begin
      check($sformatf("%s_vs_d%0d", tag, i), 64'(vs_o[i]), 64'd1);
      check($sformatf("%s_hs_d%0d", tag, i), 64'(hs_o[i]), 64'd1);
      check($sformatf("%s_de_d%0d", tag, i), 64'(de_o[i]), 64'd0);
      check($sformatf("%s_taps_d%0d", tag, i), 64'(tp_o[i]), 64'd0);
      check($sformatf("%s_rv_d%0d", tag, i), 64'(rv_o[i]), 64'd0);
      check($sformatf("%s_xp_d%0d", tag, i), 64'(xp_o[i]), 64'd0);
      check($sformatf("%s_yp_d%0d", tag, i), 64'(yp_o[i]), 64'd0);
      check($sformatf("%s_ov_d%0d", tag, i), 64'(ov_o[i]), 64'd0);
    end
  endtask

  // One clock: apply inputs, predict the outputs they produce 3 clocks later, check the
  // outputs belonging to the input applied 2 calls ago.
  task automatic cycle(input logic v, input logic h, input logic d, input logic [DW-1:0] px,
                       input int scen);
    ent_t e;
    logic [59:0] c;
    vs_in = v; hs_in = h; de_in = d; data_in = px;
    e.vs = v; e.hs = h; e.de = d; e.scen = scen; e.line = n; e.x = in_x;
    e.rv = 0; e.taps = '0;
    if (v) begin
      n = 0; in_x = 0;
    end else if (d) begin
      hist[n][in_x] = px;
      e.rv = ((n > L-1) ? L-1 : n) + 1;
      e.taps[0] = model_taps(0, 2047, n, in_x);
      e.taps[1] = model_taps(1, 2047, n, in_x);
      e.taps[2] = model_taps(0, 7, n, in_x);
      in_x++;
    end else begin
      if (prev_de_in) n++;
      in_x = 0;
    end
    prev_de_in = d;
    pipe.push_back(e);
    @(posedge clk);
    #1;
    e = pipe.pop_front();
    if (e.vs) y_exp = 1'b0;
    else if (prev_de_out && !e.de) y_exp = ~y_exp;
    if (e.de) pos = prev_de_out ? pos + 1 : 0;
    for (int i = 0; i < NT; i++) begin
      check($sformatf("vs_d%0d", i), 64'(vs_o[i]), 64'(e.vs));
      check($sformatf("hs_d%0d", i), 64'(hs_o[i]), 64'(e.hs));
      check($sformatf("de_d%0d", i), 64'(de_o[i]), 64'(e.de));
      check($sformatf("yph_d%0d", i), 64'(yp_o[i]), 64'(y_exp));
      if (e.de) begin
        check($sformatf("taps_d%0d_l%0d_x%0d", i, e.line, e.x), 64'(tp_o[i]), 64'(e.taps[i]));
        check($sformatf("rows_d%0d_l%0d", i, e.line), 64'(rv_o[i]), 64'(e.rv));
        check($sformatf("xph_d%0d_x%0d", i, e.x), 64'(xp_o[i]), 64'(pos % 2));
      end
    end
    if (e.scen == 1 && e.de) begin
      if (e.line == 0 && e.x == 3) begin
        c = {12'h003, 12'h000, 12'h000, 12'h000, 12'h000};
        check("fixed_l0x3", 64'(tp_o[0]), 64'(c));
        check("fixed_l0x3_rows", 64'(rv_o[0]), 64'd1);
      end
      if (e.line == 5 && e.x == 3) begin
        c = {12'h053, 12'h043, 12'h033, 12'h023, 12'h013};
        check("fixed_l5x3", 64'(tp_o[0]), 64'(c));
        check("fixed_l5x3_rows", 64'(rv_o[0]), 64'd5);
      end
      if (e.line == 1 && e.x == 2) begin
        c = {12'h012, 12'h002, 12'h002, 12'h002, 12'h002};
        check("fixed_repl_l1x2", 64'(tp_o[1]), 64'(c));
      end
    end
    prev_de_out = e.de;
  endtask

  task automatic vsync(input int cyc);
    for (int j = 0; j < cyc; j++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, 0);
  endtask

  // pattern=1 gives pixel = line*16 + x, otherwise random pixels.
  task automatic line(input int len, input int ln, input int scen, input bit pattern);
    for (int x = 0; x < len; x++)
      cycle(1'b0, 1'b0, 1'b1, pattern ? DW'(ln*16 + x) : DW'($urandom), scen);
    for (int j = 0; j < 4; j++)
      cycle(1'b0, 1'(j == 1 || j == 2), 1'b0, DW'($urandom), scen);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; vs_in = 1'b1; hs_in = 1'b1; de_in = 1'b0; data_in = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("rst");
    @(negedge clk);
    reset = 1'b0;

    // ramp frame, both fill modes
    vsync(4);
    for (int ln = 0; ln < 6; ln++) line(8, ln, 1, 1'b1);
    // random frame
    vsync(4);
    for (int ln = 0; ln < 7; ln++) line(8, ln, 0, 1'b0);
    // restart after line 3
    vsync(4);
    for (int ln = 0; ln < 4; ln++) line(8, ln, 0, 1'b0);
    vsync(4);
    for (int ln = 0; ln < 2; ln++) line(8, ln, 0, 1'b0);
    for (int i = 0; i < NT; i++) check($sformatf("ov_clean_d%0d", i), 64'(ov_o[i]), 64'd0);

    // overrun on the 3-bit address variant
    vsync(4);
    line(10, 0, 0, 1'b0);
    for (int i = 0; i < NT; i++)
      check($sformatf("ov_set_d%0d", i), 64'(ov_o[i]), 64'(i == 2));
    line(8, 1, 0, 1'b0);
    check("ov_sticky", 64'(ov_o[2]), 64'd1);
    vsync(2);
    for (int i = 0; i < NT; i++) check($sformatf("ov_clear_d%0d", i), 64'(ov_o[i]), 64'd0);
    vsync(2);

    // asynchronous reset in the middle of line 2
    for (int ln = 0; ln < 2; ln++) line(8, ln, 0, 1'b0);
    for (int x = 0; x < 4; x++) cycle(1'b0, 1'b0, 1'b1, DW'($urandom), 0);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("midrst");
    vs_in = 1'b0; hs_in = 1'b0; de_in = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    reset_model();
    for (int ln = 0; ln < 6; ln++) line(8, ln, 1, 1'b1);
    vsync(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bayer_linebuf_nrow.md
Name: bayer_linebuf_nrow

Overview:
- Parametrised rolling line buffer for the Bayer-to-RGB path. It presents LINES vertically aligned pixels (one column of an LINES-row window) per input pixel.
- It replaces the fixed 3-line buffer. Added features: configurable line count, rows above the top of the frame filled by border mode, a line-overflow guard, a count of valid rows, and Bayer phase flags.
- It sits between the sensor/video input stage and the demosaic kernel, which needs LINES x LINES neighbourhoods.

Parameters:
- ADDR_BITS, 11: line RAM address width. Maximum active line length is 2**ADDR_BITS pixels.
- DATA_WIDTH, 12: pixel width.
- LINES, 5: window height, legal range 2..8. The block stores LINES-1 past lines in RAM; the current line comes from a register pipeline.
- BORDER_MODE, 0: fill for rows not yet valid. 0 = zero fill; 1 = replicate the nearest valid row.
- X_PHASE_INIT, 0: x_phase value on the first pixel of each line.
- Y_PHASE_INIT, 0: y_phase value on the first line of each frame.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high.
- vs_in  in  1  vertical sync, active high; frame blanking while high.
- hs_in  in  1  horizontal sync, passed through only.
- de_in  in  1  active pixel enable.
- data_in  in  DATA_WIDTH  pixel.
- vs_out  out  1  vs_in delayed 3 cycles.
- hs_out  out  1  hs_in delayed 3 cycles.
- de_out  out  1  de_in delayed 3 cycles.
- taps_out  out  LINES*DATA_WIDTH  slice k (bits k*DW +: DW) holds the pixel from line (current - (LINES-1-k)). Slice LINES-1 is the current line; slice 0 is the oldest line.
- rows_valid  out  clog2(LINES)+1  number of valid rows in the window for the current output line, 1..LINES.
- x_phase  out  1  column parity of the output pixel.
- y_phase  out  1  row parity of the output line.
- overflow  out  1  sticky flag: a line exceeded 2**ADDR_BITS pixels. Cleared at frame start.

Behaviour:
- Reset: all outputs 0. vs_out and hs_out reset to 1, de_out resets to 0. All pointers and counters reset to 0. RAM contents are don't-care.
- Fixed latency of 3 clk from data_in/de_in to taps_out/de_out. Sync signals are delayed by the same 3 cycles, so they stay aligned with the data.
- Pipeline stage 1 (t+1) registers the following:
  - data_in, with 0 substituted while vs_in=1;
  - the column counter x, which resets to 0 when de_in=0 or vs_in=1 and otherwise increments;
  - de.
- Stage 1 also issues a read of address x in all LINES-1 RAMs.
- In the same cycle, stage 1 writes the stage-1 pixel into slot wr_slot. This is the slot holding the oldest line. The RAM is read-first, so the read returns the old content.
- Stage 2 (t+2): RAM read data is valid.
- Stage 3 (t+3): the block reorders slots by wr_slot so that slice 0 is the oldest line, and registers the result onto taps_out. The current pixel goes to slice LINES-1 through registers.
- Line end is the falling edge of stage-1 de. On line end:
  - wr_slot advances modulo LINES-1;
  - lines_done increments, saturating at LINES-1.
- vs_in=1 sets wr_slot=0 and lines_done=0. vs_in has priority over a simultaneous line end.
- rows_valid = lines_done+1. It is latched at each line start and aligned to stage 3.
- Rows with age > lines_done are invalid:
  - BORDER_MODE=0: the slice outputs 0.
  - BORDER_MODE=1: the slice outputs the oldest valid slice. With lines_done=0, all slices equal the current pixel.
- Overflow: when x reaches 2**ADDR_BITS-1 and de stays high, writes for the rest of that line are suppressed. x holds at its maximum, taps_out repeats the last stored column, and overflow sets. overflow clears on the rising edge of vs_in.
- x_phase: set to X_PHASE_INIT on the first de_out cycle of each line, then toggles every de_out cycle.
- y_phase: set to Y_PHASE_INIT while vs_out=1, and toggles on each falling edge of de_out.
- Reset asserted mid-frame: the pipeline flushes immediately. The first frame after reset starts with lines_done=0.
- taps_out while de_out=0 is don't-care but must be deterministic: it holds its last value.

Test Plan:
- LINES=5, BORDER_MODE=0, 8-pixel lines, pixel = line*16+x, 6 lines.
  - Line 0, x=3 → taps_out = {0x03,0,0,0,0} (slice 4 first), rows_valid=1.
  - Line 5, x=3 → {0x53,0x43,0x33,0x23,0x13}, rows_valid=5.
  - Output appears exactly 3 clk after the input.
- Same stimulus with BORDER_MODE=1: line 1, x=2 → {0x12,0x02,0x02,0x02,0x02}.
- Frame restart mid-frame: assert vs_in for 4 cycles after line 3.
  - Next line 0 → rows_valid=1 and zero-filled taps; no rows from the previous frame appear.
- Overflow with ADDR_BITS=3, 10-pixel line:
  - overflow=1 after the line; taps for x=8,9 repeat column 7.
  - overflow clears at the next vs_in rise.
  - The following 8-pixel line is stored correctly.
- Phase check, X/Y_PHASE_INIT=0:
  - x_phase sequence per line is 0,1,0,1…
  - y_phase is 0 on line 0 and 1 on line 1, and returns to 0 after vs.
  - Sync outputs equal the inputs delayed 3 cycles.
- Async reset asserted in the middle of line 2:
  - All outputs return to reset values within the same cycle.
  - The first frame after reset behaves exactly as in scenario 1.
